// File: rtl/pwrseq_pkg.sv
// Shared definitions for the standby power sequencers:
// FSM state encodings and 2 MHz time constants.
package pwrseq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OK   = 2'd2,
    ST_OFF  = 2'd3
  } state_e;

  localparam int T_10US_2M = 20;
  localparam int T_10MS_2M = 20000;
  localparam int T_50MS_2M = 100000;

endpackage

// File: rtl/pwrseq_dly_cnt.sv
// Load/enable saturating delay counter.
// done is registered and sticks once LIMIT cycles have elapsed.
module pwrseq_dly_cnt #(
  parameter int CNT_W = 15,
  parameter int LIMIT = 20000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic done
);

  localparam logic [CNT_W-1:0] LIM_M1 = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt;

  // Count cycles since the last load; flag once the limit is reached.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      done <= 1'b0;
    end else if (load) begin
      cnt  <= '0;
      done <= 1'b0;
    end else if (en) begin
      if (cnt != '1) cnt <= cnt + CNT_W'(1);
      done <= done | (cnt >= LIM_M1);
    end
  end

endmodule

// File: rtl/pch_vr_seq_n.sv
// N-rail standby VR sequencer: ascending power-up with dwell and PG
// timeout, strict reverse power-down, latched per-rail faults.
module pch_vr_seq_n
  import pwrseq_pkg::*;
#(
  parameter int NUM_RAILS  = 3,
  parameter int DLY_STEP   = 20,
  parameter int PG_TIMEOUT = 20000,
  parameter int PWROK_DLY  = 20000,
  parameter int CNT_W      = 15
) (
  input  logic                 iClk,
  input  logic                 iRst_n,
  input  logic                 iEnable,
  input  logic                 iAuxPwrgd,
  input  logic                 iPrsnt_n,
  input  logic [NUM_RAILS-1:0] iPwrgd,
  input  logic                 iFltClr,
  output logic [NUM_RAILS-1:0] oEn,
  output logic                 oPwrgd,
  output logic                 oPwrgdDly,
  output logic                 oFlt,
  output logic [NUM_RAILS-1:0] oFltRail,
  output logic                 oFltTimeout,
  output logic [2:0]           oState
);

  localparam int IW = (NUM_RAILS > 1) ? $clog2(NUM_RAILS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_RAILS - 1);
  localparam logic [CNT_W-1:0] STEP_M1 = CNT_W'(DLY_STEP - 1);
  localparam logic [CNT_W-1:0] TO_M1 = CNT_W'(PG_TIMEOUT - 1);

  state_e               state;
  state_e               state_n;
  logic [IW-1:0]        idx;
  logic [IW-1:0]        idx_n;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     cnt_n;
  logic [NUM_RAILS-1:0] pg_prev;
  logic [NUM_RAILS-1:0] drop;
  logic [NUM_RAILS-1:0] to_set;
  logic [NUM_RAILS-1:0] flt_set;
  logic [NUM_RAILS-1:0] flt_rail_n;
  logic                 flt_to_n;
  logic                 flt_new;
  logic                 flt_clr;
  logic [NUM_RAILS-1:0] en_n;
  logic                 dly_load;

  assign drop    = oEn & pg_prev & ~iPwrgd;
  assign flt_set = drop | to_set;
  assign flt_clr = (state == ST_IDLE) && iFltClr;
  assign oState  = {1'b0, state};

  // Next state, rail index and timeout-fault detection.
  always_comb begin
    state_n = state;
    idx_n   = idx;
    to_set  = '0;
    unique case (state)
      ST_IDLE: begin
        if (iEnable && iAuxPwrgd && !iPrsnt_n && !oFlt) begin
          state_n = ST_ON;
          idx_n   = '0;
        end
      end
      ST_ON: begin
        if (flt_new || !iEnable) begin
          state_n = ST_OFF;
        end else if (iPwrgd[idx] && cnt >= STEP_M1) begin
          if (idx == LAST) state_n = ST_OK;
          else idx_n = idx + IW'(1);
        end else if (cnt == TO_M1) begin
          to_set[idx] = 1'b1;
          state_n     = ST_OFF;
        end
      end
      ST_OK: begin
        if (flt_new || !iEnable) begin
          state_n = ST_OFF;
          idx_n   = LAST;
        end
      end
      ST_OFF: begin
        if ((!iPwrgd[idx] && cnt >= STEP_M1) || cnt == TO_M1) begin
          if (idx == '0) state_n = ST_IDLE;
          else idx_n = idx - IW'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Step counter restarts on any state/index change, else saturates.
  always_comb begin
    cnt_n = '0;
    if (state_n == state && idx_n == idx)
      cnt_n = (cnt == '1) ? cnt : cnt + CNT_W'(1);
  end

  // Enable pattern for the upcoming state: rails 0..idx on while rising,
  // rails below idx on while falling.
  always_comb begin
    en_n = '0;
    for (int r = 0; r < NUM_RAILS; r++) begin
      unique case (state_n)
        ST_ON:   en_n[r] = (r <= int'(idx_n));
        ST_OK:   en_n[r] = 1'b1;
        ST_OFF:  en_n[r] = (r < int'(idx_n));
        default: en_n[r] = 1'b0;
      endcase
    end
  end

  // Fault latch: set events win over a clear in the same cycle.
  always_comb begin
    flt_rail_n = flt_clr ? flt_set : (oFltRail | flt_set);
    flt_to_n   = flt_clr ? (|to_set) : (oFltTimeout | (|to_set));
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state       <= ST_IDLE;
      idx         <= '0;
      cnt         <= '0;
      pg_prev     <= '0;
      flt_new     <= 1'b0;
      oEn         <= '0;
      oPwrgd      <= 1'b0;
      oFlt        <= 1'b0;
      oFltRail    <= '0;
      oFltTimeout <= 1'b0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      cnt         <= cnt_n;
      pg_prev     <= iPwrgd;
      flt_new     <= |flt_set;
      oEn         <= en_n;
      oPwrgd      <= (state_n == ST_OK);
      oFlt        <= |flt_rail_n;
      oFltRail    <= flt_rail_n;
      oFltTimeout <= flt_to_n;
    end
  end

  assign dly_load = !(state == ST_OK && state_n == ST_OK);

  pwrseq_dly_cnt #(
    .CNT_W (CNT_W),
    .LIMIT (PWROK_DLY)
  ) u_pwrok_dly (
    .clk   (iClk),
    .rst_n (iRst_n),
    .load  (dly_load),
    .en    (1'b1),
    .done  (oPwrgdDly)
  );

endmodule

// File: tb/tb_pch_vr_seq_n.sv
// Bench for pch_vr_seq_n: directed scenarios plus random traffic,
// every cycle compared against a behavioural model.
module tb_pch_vr_seq_n;

  localparam int N  = 3;
  localparam int D  = 4;
  localparam int TO = 50;
  localparam int PD = 10;
  localparam int MAXC = 32767;

  logic clk = 1'b0;
  logic rst_n, en, aux, prs_n, clr;
  logic [N-1:0] pwrgd;
  logic [N-1:0] o_en, o_frail;
  logic o_pg, o_pgd, o_flt, o_fto;
  logic [2:0] o_state;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [N-1:0] d1, d2, force_low, drop_mask;

  int m_mode, m_k, m_t, m_age;
  logic [N-1:0] m_en, m_pgp, m_fr;
  logic m_to, m_newf, m_pwrgd, m_dly;

  always #5 clk = ~clk;

  pch_vr_seq_n #(
    .NUM_RAILS (N), .DLY_STEP (D), .PG_TIMEOUT (TO),
    .PWROK_DLY (PD), .CNT_W (15)
  ) dut (
    .iClk (clk), .iRst_n (rst_n), .iEnable (en),
    .iAuxPwrgd (aux), .iPrsnt_n (prs_n), .iPwrgd (pwrgd),
    .iFltClr (clr), .oEn (o_en), .oPwrgd (o_pg),
    .oPwrgdDly (o_pgd), .oFlt (o_flt), .oFltRail (o_frail),
    .oFltTimeout (o_fto), .oState (o_state)
  );

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_k = 0; m_t = 0; m_age = 0;
    m_en = '0; m_pgp = '0; m_fr = '0;
    m_to = 0; m_newf = 0; m_pwrgd = 0; m_dly = 0;
  endtask

  // Rules of the sequencer evaluated at a clock edge from the inputs.
  task automatic model_step();
    logic [N-1:0] pg, drp, tos;
    int nm, nk;
    pg  = pwrgd;
    drp = m_en & m_pgp & ~pg;
    tos = '0;
    nm  = m_mode;
    nk  = m_k;
    case (m_mode)
      0: if (en && aux && !prs_n && m_fr == 0) begin
        nm = 1; nk = 0;
      end
      1: begin
        if (m_newf || !en) nm = 3;
        else if (pg[m_k] && m_t >= D - 1) begin
          if (m_k == N - 1) nm = 2;
          else nk = m_k + 1;
        end else if (m_t == TO - 1) begin
          tos[m_k] = 1'b1; nm = 3;
        end
      end
      2: if (m_newf || !en) begin
        nm = 3; nk = N - 1;
      end
      default: if ((!pg[m_k] && m_t >= D - 1) || m_t == TO - 1) begin
        if (m_k == 0) nm = 0;
        else nk = m_k - 1;
      end
    endcase
    if (nm != m_mode || nk != m_k) m_t = 0;
    else if (m_t < MAXC) m_t = m_t + 1;
    if (m_mode == 0 && clr) begin
      m_fr = drp | tos; m_to = |tos;
    end else begin
      m_fr = m_fr | drp | tos; m_to = m_to | (|tos);
    end
    m_newf = |(drp | tos);
    m_age = (m_mode == 2 && nm == 2) ? m_age + 1 : 0;
    m_mode = nm;
    m_k = nk;
    case (nm)
      1: m_en = N'((1 << (nk + 1)) - 1);
      2: m_en = N'((1 << N) - 1);
      3: m_en = N'((1 << nk) - 1);
      default: m_en = '0;
    endcase
    m_pgp = pg;
    m_pwrgd = (nm == 2);
    m_dly = (nm == 2) && (m_age >= PD);
  endtask

  task automatic apply_pg();
    pwrgd = d2 & ~force_low & ~drop_mask;
  endtask

  task automatic plant_reset();
    d1 = '0; d2 = '0; apply_pg();
  endtask

  task automatic tick();
    logic [12:0] act, exp;
    @(posedge clk);
    cyc++;
    model_step();
    @(negedge clk);
    act = {o_state, o_en, o_pg, o_pgd, o_flt, o_frail, o_fto};
    exp = {3'(m_mode), m_en, m_pwrgd, m_dly, |m_fr, m_fr, m_to};
    chk("model", 32'(act), 32'(exp));
    d2 = d1;
    d1 = o_en;
    apply_pg();
  endtask

  function automatic logic probe(int sel);
    case (sel)
      0, 1, 2: return o_en[sel];
      3: return o_pg;
      4: return o_pgd;
      5: return o_fto;
      6: return o_state == 3'd0;
      default: return o_flt;
    endcase
  endfunction

  task automatic wait_sig(string nm, int sel, logic val, int budget,
                          output int c);
    int n = 0;
    while (probe(sel) !== val && n < budget) begin
      tick(); n++;
    end
    chk(nm, 32'(probe(sel)), 32'(val));
    c = cyc;
  endtask

  initial begin
    int c0, c1, c2, c3, c4, cx;
    rst_n = 0; en = 0; aux = 0; prs_n = 1; clr = 0;
    force_low = '0; drop_mask = '0;
    model_reset();
    plant_reset();
    repeat (3) @(negedge clk);
    chk("reset_outs", 32'({o_en, o_pg, o_pgd, o_flt, o_frail, o_fto}), 0);
    chk("reset_state", 32'(o_state), 0);
    rst_n = 1;
    repeat (3) tick();

    // normal power-up
    en = 1; aux = 1; prs_n = 0;
    wait_sig("up_en0", 0, 1, 20, c0);
    wait_sig("up_en1", 1, 1, 20, c1);
    wait_sig("up_en2", 2, 1, 20, c2);
    wait_sig("up_pg", 3, 1, 20, c3);
    wait_sig("up_pgd", 4, 1, 40, c4);
    chk("spacing_01", 32'(c1 - c0), 4);
    chk("spacing_12", 32'(c2 - c1), 4);
    chk("pg_after_en2", 32'(c3 - c2), 4);
    chk("pgd_after_pg", 32'(c4 - c3), 10);
    repeat (5) tick();

    // PG drop on rail 1 in ST_OK; clear attempt in ST_OK is ignored
    drop_mask = 3'b010; apply_pg();
    tick();
    chk("drop_rail", 32'(o_frail), 32'h2);
    chk("drop_flt", 32'(o_flt), 1);
    chk("drop_still_ok", 32'({o_state, o_pg}), 32'h5);
    clr = 1;
    tick();
    clr = 0;
    chk("drop_off_outs", 32'({o_pg, o_pgd, o_en}), 32'h3);
    chk("clr_in_ok_ignored", 32'(o_frail), 32'h2);
    wait_sig("drop_en1_off", 1, 0, 20, c1);
    wait_sig("drop_en0_off", 0, 0, 20, c0);
    chk("drop_order", 32'(c0 > c1), 1);
    wait_sig("drop_idle", 6, 1, 20, cx);
    repeat (20) tick();
    chk("no_restart", 32'({o_state, o_en}), 0);

    // fault clear restarts with iEnable held
    drop_mask = '0; apply_pg();
    clr = 1;
    tick();
    clr = 0;
    chk("clr_rail", 32'({o_flt, o_frail, o_fto}), 0);
    wait_sig("restart_pg", 3, 1, 60, cx);

    // PG timeout on rail 2
    en = 0;
    wait_sig("to_idle0", 6, 1, 60, cx);
    force_low = 3'b100; apply_pg();
    en = 1;
    wait_sig("to_en2", 2, 1, 40, c2);
    wait_sig("to_flag", 5, 1, 80, c3);
    chk("to_delay", 32'(c3 - c2), 50);
    chk("to_rail", 32'(o_frail), 32'h4);
    chk("to_en", 32'(o_en), 32'h3);
    wait_sig("to_idle", 6, 1, 60, cx);
    force_low = '0; apply_pg();
    clr = 1; en = 0;
    tick();
    clr = 0;
    chk("to_clr", 32'({o_flt, o_fto}), 0);

    // iEnable drop while rising at idx 1
    en = 1;
    wait_sig("ed_en1", 1, 1, 20, cx);
    en = 0;
    tick();
    chk("ed_first", 32'({o_state, o_en}), 32'h19);
    wait_sig("ed_idle", 6, 1, 40, cx);
    chk("ed_noflt", 32'({o_flt, o_frail, o_fto}), 0);

    // asynchronous reset while rising at idx 2
    en = 1;
    wait_sig("rst_en2", 2, 1, 30, cx);
    #2 rst_n = 0;
    #1;
    chk("rst_async_en", 32'({o_en, o_pg, o_pgd}), 0);
    chk("rst_async_state", 32'(o_state), 0);
    model_reset();
    plant_reset();
    @(negedge clk);
    rst_n = 1;

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 15) == 0) en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 31) == 0) aux = ($urandom_range(0, 5) != 0);
      if ($urandom_range(0, 31) == 0) prs_n = ($urandom_range(0, 7) == 0);
      clr = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 63) == 0) force_low = N'($urandom);
      else if ($urandom_range(0, 15) == 0) force_low = '0;
      if ($urandom_range(0, 47) == 0) drop_mask = N'($urandom);
      else if ($urandom_range(0, 7) == 0) drop_mask = '0;
      apply_pg();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pch_vr_seq_n.md
# pch_vr_seq_n

Parametrised N-rail standby VR sequencer: the successor to the fixed two-rail PCH AUX sequencer in the power-sequencing tree. It enables NUM_RAILS regulators in ascending order with a minimum per-rail dwell and a power-good timeout, and latches per-rail faults (PG drop or PG timeout). It powers down in strict reverse order and produces a delayed power-OK for RSMRST#-style consumers. It runs in S5, independent of the master sequencer.

## Interface

Parameters:
- NUM_RAILS, 3, number of sequenced rails; index 0 powers first.
- DLY_STEP, 20, minimum dwell per rail, in cycles (10 µs at 2 MHz).
- PG_TIMEOUT, 20000, maximum cycles to wait for a rail PG edge; must exceed DLY_STEP.
- PWROK_DLY, 20000, cycles oPwrgd must be held before oPwrgdDly asserts.
- CNT_W, 15, counter width; must satisfy 2^CNT_W > max(PG_TIMEOUT, PWROK_DLY).

Ports:
- iClk, in, 1, sequencing clock.
- iRst_n, in, 1, reset; asynchronous, active-low.
- iEnable, in, 1, power-up request.
- iAuxPwrgd, in, 1, upstream AUX rail good; this is a prerequisite for starting.
- iPrsnt_n, in, 1, device present, active-low.
- iPwrgd, in, NUM_RAILS, per-rail PG; already synchronous to iClk.
- iFltClr, in, 1, clears latched faults; honoured only in ST_IDLE.
- oEn, out, NUM_RAILS, per-rail VR enables.
- oPwrgd, out, 1, all rails up.
- oPwrgdDly, out, 1, oPwrgd held for PWROK_DLY cycles.
- oFlt, out, 1, any latched fault.
- oFltRail, out, NUM_RAILS, one-hot per-rail latched fault; bits accumulate.
- oFltTimeout, out, 1, at least one fault was a PG timeout.
- oState, out, 3, current FSM state, for debug.

## Operation

- The FSM has four states: ST_IDLE = 0, ST_ON = 1, ST_OK = 2, ST_OFF = 3. It uses a rail index `idx` and a step counter `cnt`. `cnt` clears whenever the state or `idx` changes and otherwise increments, saturating at all-ones.
- **ST_IDLE:** all outputs except the fault flags are 0. The FSM moves to ST_ON with idx = 0 when iEnable && iAuxPwrgd && !iPrsnt_n && !oFlt.
- **ST_ON:** oEn[idx] is 1; lower rails stay enabled. Exits are evaluated in this priority order:
  1. New fault or !iEnable: go to ST_OFF at the current idx.
  2. iPwrgd[idx] && cnt ≥ DLY_STEP−1: if idx = NUM_RAILS−1, go to ST_OK; otherwise idx++.
  3. cnt = PG_TIMEOUT−1 with iPwrgd[idx] low: set oFltRail[idx] and oFltTimeout, then go to ST_OFF.
- **ST_OK:** oPwrgd is 1. On a new fault or !iEnable, go to ST_OFF with idx = NUM_RAILS−1.
- **ST_OFF:** oEn[idx] is 0. The FSM advances when (!iPwrgd[idx] && cnt ≥ DLY_STEP−1) or cnt = PG_TIMEOUT−1. A forced advance on timeout raises no fault. At idx = 0 it goes to ST_IDLE; otherwise idx−−. Rails above idx are already off.
- **PG-drop fault:** for rail i, oEn[i] && pgPrev[i] && !iPwrgd[i], where pgPrev is iPwrgd registered one cycle. This latches oFltRail[i]. Detection runs in every state.
- **Fault latch behaviour:**
  - oFlt is the OR of oFltRail.
  - Latched faults persist until iFltClr is sampled in ST_IDLE; in that case all fault outputs clear on the next edge.
  - A set event and iFltClr in the same cycle: the set wins.
- **Power-down order:** reverse order is guaranteed. A lower rail is never disabled while a higher rail is enabled.

## Timing

- Every output resets to 0, state resets to ST_IDLE, and idx/cnt reset to 0.
- All outputs are registered. oEn[idx] rises on the same edge the FSM enters ST_ON for that idx, and falls on the edge it enters ST_OFF for that idx.
- Minimum rail-to-rail enable spacing is DLY_STEP cycles.
- A fault sampled at edge t moves the FSM to ST_OFF at t+1. On that edge oPwrgd and oPwrgdDly drop, together with the first oEn deassertion.
- oPwrgd rises on the edge the FSM enters ST_OK. oPwrgdDly rises exactly PWROK_DLY cycles later and falls on the same edge as oPwrgd.
- If iEnable returns during ST_OFF, it is ignored until ST_IDLE is reached.
- Asserting iRst_n mid-sequence drops all enables immediately (asynchronous).

## Structure

- A shared package `pwrseq_pkg` holds the state encodings and the 2 MHz time constants (T_10US_2M, T_10MS_2M, T_50MS_2M), reused by sibling sequencers.
- One natural sub-module, `pwrseq_dly_cnt`: a load/enable saturating delay counter with a done flag, used for PWROK_DLY.
- The step counter stays inline.

## Test plan

All scenarios use NUM_RAILS=3, DLY_STEP=4, PG_TIMEOUT=50, PWROK_DLY=10; the PG model responds 2 cycles after each enable.

- **Normal power-up:** oEn[0], oEn[1], oEn[2] rise 4 cycles apart. oPwrgd rises 4 cycles after oEn[2], and oPwrgdDly rises 10 cycles after that.
- **PG drop in ST_OK:** iPwrgd[1] drops → oFltRail = 3'b010 and oFlt = 1. oPwrgd and oPwrgdDly fall next cycle, and enables fall in the order 2, 1, 0. No restart occurs while iEnable stays high.
- **PG timeout:** iPwrgd[2] is held low → 50 cycles after oEn[2] rises, oFltRail = 3'b100 and oFltTimeout = 1, followed by reverse shutdown.
- **iEnable drop mid-sequence:** iEnable falls in ST_ON with idx = 1 → oEn[1] falls first, then oEn[0]. No fault flags are set and the FSM returns to ST_IDLE.
- **Fault clear:** iFltClr in ST_IDLE clears all fault flags, and a held iEnable restarts the sequence. iFltClr in ST_OK has no effect.
- **Reset mid-sequence:** iRst_n pulses low during ST_ON at idx = 2 → all outputs are 0 asynchronously and oState = 0.
